// File: rtl/acq_sequencer_pkg.sv
// acq_sequencer_pkg: state encodings and default delay constants for acq_sequencer
package acq_sequencer_pkg;
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    START_BUF = 4'd1,
    WAIT_BUF  = 4'd2,
    READY     = 4'd3,
    WAIT_HOST = 4'd4,
    SPI_START = 4'd5,
    SPI_RUN   = 4'd6,
    STOP      = 4'd7,
    ERROR     = 4'd8
  } state_t;
  localparam int DEF_READY_CYCLES   = 30;
  localparam int DEF_STOP_DELAY     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 65535;
endpackage

// File: rtl/acq_sequencer_delay_cnt.sv
// acq_delay_cnt: loadable down-counter with zero flag, shared by ready/stop/timeout phases
module acq_delay_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);
  // load has priority; otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - CNT_W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/acq_sequencer.sv
// acq_sequencer: round-robin buffer fill / host handshake / SPI transfer sequencer
module acq_sequencer
  import acq_sequencer_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int CH_W           = 2,
  parameter int READY_CYCLES   = DEF_READY_CYCLES,
  parameter int STOP_DELAY     = DEF_STOP_DELAY,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 16
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            ENABLE,
  input  logic            CONTINUOUS,
  input  logic            ABORT,
  output logic [N_CH-1:0] START_BUFER,
  input  logic [N_CH-1:0] STOP_BUFER,
  output logic            READY_TRANS,
  input  logic            START_TRANSLATION,
  output logic            START_SPI_TRANS,
  input  logic            STOP_SPI_TRANS,
  output logic            SWITCH,
  output logic            STOP_TRANSLATION,
  output logic [CH_W-1:0] CH_SEL,
  output logic            TIMEOUT_ERR,
  output logic [3:0]      STATE
);
  localparam logic [CNT_W-1:0] LD_TO   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LD_RDY  = CNT_W'(READY_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_STOP = CNT_W'(STOP_DELAY - 1);
  localparam bit TO_EN = TIMEOUT_CYCLES != 0;
  state_t state;
  logic armed, abort, buf_hit, last_ch, expire, timeout, cnt_load, zero;
  logic [N_CH-1:0] sel_oh;
  logic [CNT_W-1:0] cnt, cnt_val;
  assign STATE = state;
  assign sel_oh = N_CH'(1) << CH_SEL;
  assign buf_hit = |(STOP_BUFER & sel_oh);
  assign last_ch = CH_SEL == CH_W'(N_CH - 1);
  assign abort = ABORT && state != IDLE && state != ERROR;
  // counter was loaded with TIMEOUT_CYCLES on entry, so the last allowed cycle sees 1
  assign expire = TO_EN && cnt <= CNT_W'(1);
  // the awaited event beats expiry in the same cycle
  assign timeout = expire && (state == WAIT_BUF ? !buf_hit :
                              state == WAIT_HOST ? !START_TRANSLATION :
                              state == SPI_RUN && !STOP_SPI_TRANS);
  assign cnt_load = abort || state == START_BUF || state == SPI_START || (state == READY && zero) ||
                    (state == WAIT_BUF && buf_hit) || (state == SPI_RUN && STOP_SPI_TRANS);
  assign cnt_val = abort ? '0 : state == WAIT_BUF ? LD_RDY : state == SPI_RUN ? LD_STOP : LD_TO;
  acq_delay_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk(CLK), .rst_n(RESET_N), .load(cnt_load), .load_val(cnt_val), .cnt(cnt), .zero(zero)
  );
  // sequencer FSM with registered outputs; abort, then timeout, then per-state transitions
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= IDLE;
      CH_SEL <= '0;
      SWITCH <= 1'b1;
      TIMEOUT_ERR <= 1'b0;
      START_BUFER <= '0;
      READY_TRANS <= 1'b0;
      START_SPI_TRANS <= 1'b0;
      STOP_TRANSLATION <= 1'b0;
      armed <= 1'b1;
    end else if (abort) begin
      state <= IDLE;
      SWITCH <= 1'b1;
      START_BUFER <= '0;
      READY_TRANS <= 1'b0;
      START_SPI_TRANS <= 1'b0;
      STOP_TRANSLATION <= 1'b0;
    end else if (timeout) begin
      state <= ERROR;
      TIMEOUT_ERR <= 1'b1;
      SWITCH <= 1'b1;
      READY_TRANS <= 1'b0;
      STOP_TRANSLATION <= 1'b0;
    end else
      case (state)
        IDLE: begin
          if (!ENABLE) armed <= 1'b1;
          if (ENABLE && armed) begin
            state <= START_BUF;
            START_BUFER <= sel_oh;
          end
        end
        START_BUF: begin
          state <= WAIT_BUF;
          START_BUFER <= '0;
        end
        WAIT_BUF: if (buf_hit) begin
          state <= READY;
          READY_TRANS <= 1'b1;
        end
        READY: if (zero) begin
          state <= WAIT_HOST;
          READY_TRANS <= 1'b0;
        end
        WAIT_HOST: if (START_TRANSLATION) begin
          state <= SPI_START;
          START_SPI_TRANS <= 1'b1;
          SWITCH <= 1'b0;
        end
        SPI_START: begin
          state <= SPI_RUN;
          START_SPI_TRANS <= 1'b0;
        end
        SPI_RUN: if (STOP_SPI_TRANS) begin
          state <= STOP;
          SWITCH <= 1'b1;
          STOP_TRANSLATION <= 1'b1;
        end
        STOP: if (zero) begin
          state <= IDLE;
          STOP_TRANSLATION <= 1'b0;
          CH_SEL <= last_ch ? '0 : CH_SEL + CH_W'(1);
          if (last_ch && !CONTINUOUS) armed <= 1'b0;
        end
        ERROR: if (!ENABLE) begin
          state <= IDLE;
          TIMEOUT_ERR <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule
